// File: rtl/nibser_pkg.sv
// Shared definitions for the nibble serializer: FSM state encoding,
// default parameter values and a counter-width helper.
package nibser_pkg;

   localparam int DATA_W_DEF   = 4;
   localparam int WAIT_CYC_DEF = 2;
   localparam int CNT_W_DEF    = 8;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_REQ   = 3'd1,
      ST_WAIT  = 3'd2,
      ST_START = 3'd3,
      ST_SHIFT = 3'd4,
      ST_STOP  = 3'd5
   } state_e;

   // Bits needed to hold values 0..max_val, never less than one bit.
   function automatic int cnt_width(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/nibble_serializer.sv
// Requests a nibble from a producer, samples it after a fixed wait and
// sends it on sdo as a start bit, DATA_W data bits MSB first, and a stop bit.
module nibble_serializer
   import nibser_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int WAIT_CYC = WAIT_CYC_DEF,
   parameter int CNT_W    = CNT_W_DEF
) (
   input  logic              sclk,
   input  logic              rst,
   input  logic              enable,
   input  logic [DATA_W-1:0] data,
   output logic              ask_for_data,
   output logic              sdo,
   output logic              busy,
   output logic              frame_done,
   output logic [CNT_W-1:0]  frame_cnt
);

   localparam int BIT_W  = cnt_width(DATA_W - 1);
   localparam int WAIT_W = cnt_width(WAIT_CYC);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_CYC - 1);

   state_e              r_state;
   state_e              w_next_state;
   logic                r_ask;
   logic                r_sdo;
   logic                w_ask_next;
   logic                w_sdo_next;
   logic [DATA_W-1:0]   r_shift;
   logic [BIT_W-1:0]    r_bit_cnt;
   logic [WAIT_W-1:0]   r_wait_cnt;
   logic [CNT_W-1:0]    r_frame_cnt;

   // NOTE: every signal gets a default before the case so no path leaves it
   // unassigned; otherwise synthesis would infer a latch.
   always_comb begin
      w_next_state = r_state;
      w_ask_next   = 1'b0;
      w_sdo_next   = 1'b1;

      case (r_state)
         ST_IDLE:  if (enable) w_next_state = ST_REQ;
         ST_REQ:   w_next_state = ST_WAIT;
         ST_WAIT:  if (r_wait_cnt == WAIT_LAST) w_next_state = ST_START;
         ST_START: w_next_state = ST_SHIFT;
         ST_SHIFT: if (r_bit_cnt == BIT_LAST) w_next_state = ST_STOP;
         ST_STOP:  w_next_state = ST_IDLE;
         default:  w_next_state = ST_IDLE;
      endcase

      // Outputs are decoded from the next state so the registered copies
      // line up exactly with the state they belong to.
      case (w_next_state)
         ST_REQ:   w_ask_next = 1'b1;
         ST_START: w_sdo_next = 1'b0;
         ST_SHIFT: w_sdo_next = r_shift[DATA_W-1];
         default:  ;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge sclk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_ask   <= 1'b0;
         r_sdo   <= 1'b1;
      end else begin
         r_state <= w_next_state;
         r_ask   <= w_ask_next;
         r_sdo   <= w_sdo_next;
      end
   end

   // NOTE: the shift register is reset along with the control state so an
   // aborted frame leaves no stale bits behind.
   always_ff @(posedge sclk or posedge rst) begin
      if (rst) begin
         r_shift     <= '0;
         r_bit_cnt   <= '0;
         r_wait_cnt  <= '0;
         r_frame_cnt <= '0;
      end else begin
         if (r_state == ST_WAIT && w_next_state == ST_START) begin
            r_shift <= data;
         end else if (w_next_state == ST_SHIFT) begin
            r_shift <= r_shift << 1;
         end

         if (r_state == ST_WAIT && w_next_state == ST_WAIT) begin
            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
         end else begin
            r_wait_cnt <= '0;
         end

         if (r_state == ST_SHIFT && w_next_state == ST_SHIFT) begin
            r_bit_cnt <= r_bit_cnt + BIT_W'(1);
         end else begin
            r_bit_cnt <= '0;
         end

         if (r_state == ST_STOP) begin
            r_frame_cnt <= r_frame_cnt + CNT_W'(1);
         end
      end
   end

   assign ask_for_data = r_ask;
   assign sdo          = r_sdo;
   assign busy         = (r_state != ST_IDLE);
   assign frame_done   = (r_state == ST_STOP);
   assign frame_cnt    = r_frame_cnt;

endmodule

// File: tb/tb_nibble_serializer.sv
// Directed bench for nibble_serializer: reset, single frame, sample window,
// mid-frame enable drop and reset, and streaming with frame counter wrap.
module tb_nibble_serializer;

   localparam int DW = 4;
   localparam int WC = 2;
   localparam int CW = 8;
   localparam int FL = 1 + WC + 1 + DW + 1;

   logic          sclk = 1'b0;
   logic          rst;
   logic          enable;
   logic [DW-1:0] data;
   logic          ask_for_data;
   logic          sdo;
   logic          busy;
   logic          frame_done;
   logic [CW-1:0] frame_cnt;

   int            n_cmp = 0;
   int            n_err = 0;
   logic [CW-1:0] exp_cnt;

   always #5 sclk = ~sclk;

   nibble_serializer #(
      .DATA_W   (DW),
      .WAIT_CYC (WC),
      .CNT_W    (CW)
   ) dut (
      .sclk         (sclk),
      .rst          (rst),
      .enable       (enable),
      .data         (data),
      .ask_for_data (ask_for_data),
      .sdo          (sdo),
      .busy         (busy),
      .frame_done   (frame_done),
      .frame_cnt    (frame_cnt)
   );

   task automatic tick();
      @(posedge sclk);
      @(negedge sclk);
   endtask

   // Expected {ask_for_data, sdo, frame_done, busy} in cycle c of a frame,
   // c = 1 being the REQ cycle; cycles past the frame are idle.
   function automatic logic [3:0] exp_out(input logic [DW-1:0] d, input int c);
      logic s;
      s = 1'b1;
      if (c == WC + 2) s = 1'b0;
      else if (c >= WC + 3 && c <= WC + 2 + DW) s = d[DW-1-(c-WC-3)];
      return {(c == 1), s, (c == FL), (c <= FL)};
   endfunction

   task automatic test_reset();
      enable = 1'b0;
      data   = '0;
      rst    = 1'b0;
      #2 rst = 1'b1;
      #1;
      n_cmp++;
      if ({ask_for_data, sdo, frame_done, busy} !== 4'b0100) begin
         n_err++;
         $display("FAIL reset_outputs: got %b want 0100", {ask_for_data, sdo, frame_done, busy});
      end
      n_cmp++;
      if (frame_cnt !== 8'd0) begin
         n_err++;
         $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt);
      end
      @(negedge sclk);
      rst = 1'b0;
      exp_cnt = '0;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++;
         if ({ask_for_data, sdo, frame_done, busy} !== 4'b0100) begin
            n_err++;
            $display("FAIL idle_without_enable[%0d]: got %b want 0100", i, {ask_for_data, sdo, frame_done, busy});
         end
      end
   endtask

   task automatic test_mid_frame_reset();
      data   = 4'hB;
      enable = 1'b1;
      for (int c = 1; c <= WC + 4; c++) begin
         tick();
         if (c == 1) enable = 1'b0;
      end
      n_cmp++;
      if (sdo !== 1'b0) begin
         n_err++;
         $display("FAIL rst_pre_sdo: got %b want 0", sdo);
      end
      #1 rst = 1'b1;
      #1;
      n_cmp++;
      if ({ask_for_data, sdo, frame_done, busy} !== 4'b0100) begin
         n_err++;
         $display("FAIL rst_mid_outputs: got %b want 0100", {ask_for_data, sdo, frame_done, busy});
      end
      @(negedge sclk);
      rst = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         n_cmp++;
         if (frame_done !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL rst_aborted[%0d]: done=%b busy=%b want 0 0", i, frame_done, busy);
         end
      end
      n_cmp++;
      if (frame_cnt !== exp_cnt) begin
         n_err++;
         $display("FAIL rst_frame_cnt: got %0d want %0d", frame_cnt, exp_cnt);
      end
   endtask

   task automatic test_single_frame();
      data   = 4'h5;
      enable = 1'b1;
      for (int c = 1; c <= FL + 3; c++) begin
         tick();
         n_cmp++;
         if ({ask_for_data, sdo, frame_done, busy} !== exp_out(4'hA, c)) begin
            n_err++;
            $display("FAIL single_c%0d: got %b want %b", c, {ask_for_data, sdo, frame_done, busy}, exp_out(4'hA, c));
         end
         if (c == 1) begin
            enable = 1'b0;
            data   = 4'hA;
         end
      end
      exp_cnt++;
      n_cmp++;
      if (frame_cnt !== exp_cnt) begin
         n_err++;
         $display("FAIL single_frame_cnt: got %0d want %0d", frame_cnt, exp_cnt);
      end
   endtask

   task automatic test_sample_window();
      data   = 4'h3;
      enable = 1'b1;
      for (int c = 1; c <= FL + 1; c++) begin
         tick();
         n_cmp++;
         if ({ask_for_data, sdo, frame_done, busy} !== exp_out(4'hC, c)) begin
            n_err++;
            $display("FAIL window_c%0d: got %b want %b", c, {ask_for_data, sdo, frame_done, busy}, exp_out(4'hC, c));
         end
         if (c == 1) enable = 1'b0;
         if (c == 2) data = 4'hC;
         if (c == WC + 2) data = 4'h0;
      end
      exp_cnt++;
      n_cmp++;
      if (frame_cnt !== exp_cnt) begin
         n_err++;
         $display("FAIL window_frame_cnt: got %0d want %0d", frame_cnt, exp_cnt);
      end
   endtask

   task automatic test_enable_drop();
      data   = 4'h9;
      enable = 1'b1;
      for (int c = 1; c <= FL + 4; c++) begin
         tick();
         n_cmp++;
         if ({ask_for_data, sdo, frame_done, busy} !== exp_out(4'h9, c)) begin
            n_err++;
            $display("FAIL drop_c%0d: got %b want %b", c, {ask_for_data, sdo, frame_done, busy}, exp_out(4'h9, c));
         end
         if (c == WC + 4) enable = 1'b0;
      end
      exp_cnt++;
      n_cmp++;
      if (frame_cnt !== exp_cnt) begin
         n_err++;
         $display("FAIL drop_frame_cnt: got %0d want %0d", frame_cnt, exp_cnt);
      end
   endtask

   task automatic test_back_to_back();
      logic          prev_ask;
      logic [DW-1:0] exp_d;
      prev_ask = 1'b0;
      data     = '0;
      enable   = 1'b1;
      for (int f = 0; f < 260; f++) begin
         exp_d = DW'(f + 1);
         for (int c = 1; c <= FL + 1; c++) begin
            tick();
            n_cmp++;
            if ({ask_for_data, sdo, frame_done, busy} !== exp_out(exp_d, c)) begin
               n_err++;
               $display("FAIL stream_f%0d_c%0d: got %b want %b", f, c, {ask_for_data, sdo, frame_done, busy}, exp_out(exp_d, c));
            end
            if (ask_for_data && !prev_ask) data = data + 1'b1;
            prev_ask = ask_for_data;
            if (c == FL + 1) begin
               exp_cnt++;
               n_cmp++;
               if (frame_cnt !== exp_cnt) begin
                  n_err++;
                  $display("FAIL stream_cnt_f%0d: got %0d want %0d", f, frame_cnt, exp_cnt);
               end
               if (f == 259) enable = 1'b0;
            end
         end
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++;
         if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL stream_end_idle[%0d]: got %b want 0", i, busy);
         end
      end
   endtask

   initial begin
      test_reset();
      test_mid_frame_reset();
      test_single_frame();
      test_sample_window();
      test_enable_drop();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/nibble_serializer.md
NIBBLE_SERIALIZER -- requirements
Module: nibble_serializer

Interface
REQ-001 Parameter DATA_W, default 4, SHALL set the nibble width received on data and shifted out per frame.
REQ-002 Parameter WAIT_CYC, default 2, legal range 1..15, SHALL set the number of sclk cycles between the end of the request and the data sample.
REQ-003 Parameter CNT_W, default 8, SHALL set the width of frame_cnt.
REQ-004 Port sclk, input, 1 bit, SHALL be the sole clock; all state updates on rising edge.
REQ-005 Port rst, input, 1 bit, SHALL be the asynchronous, active-high reset.
REQ-006 Port enable, input, 1 bit, SHALL be the request to start frames, sampled only in IDLE.
REQ-007 Port data, input, DATA_W bits, SHALL be the parallel nibble supplied by the producer.
REQ-008 Port ask_for_data, output, 1 bit, SHALL be the registered request strobe to the producer.
REQ-009 Port sdo, output, 1 bit, SHALL be the registered serial data line, idle high.
REQ-010 Port busy, output, 1 bit, SHALL be high whenever state is not IDLE.
REQ-011 Port frame_done, output, 1 bit, SHALL be a one-cycle pulse during the STOP cycle.
REQ-012 Port frame_cnt, output, CNT_W bits, SHALL count completed frames.

Function
REQ-013 FSM states SHALL be IDLE, REQ, WAIT, START, SHIFT, STOP.
REQ-014 IDLE -> REQ on an edge where enable=1; otherwise stay IDLE.
REQ-015 REQ SHALL last exactly 1 cycle with ask_for_data=1; ask_for_data=0 in every other state, giving a clean rising edge per frame.
REQ-016 WAIT SHALL last exactly WAIT_CYC cycles; on the edge leaving WAIT, data SHALL be captured into the shift register; data at all other times SHALL be ignored.
REQ-017 START SHALL last 1 cycle with sdo=0.
REQ-018 SHIFT SHALL last DATA_W cycles, driving the captured nibble MSB first, one bit per cycle.
REQ-019 STOP SHALL last 1 cycle with sdo=1 and frame_done=1, then return to IDLE.
REQ-020 sdo SHALL be 1 in IDLE, REQ and WAIT.
REQ-021 Frame length SHALL be 1+WAIT_CYC+1+DATA_W+1 cycles; with defaults, 9 cycles. Back-to-back frames with enable held high SHALL be separated by exactly 1 IDLE cycle.
REQ-022 Deasserting enable mid-frame SHALL NOT abort the frame; the frame completes and the block then stays IDLE.
REQ-023 frame_cnt SHALL increment by 1 on the edge leaving STOP and wrap modulo 2^CNT_W (255 -> 0 for the default).
REQ-024 A bit counter SHALL be sized for DATA_W-1, and a wait counter SHALL be sized for WAIT_CYC, with no overflow for legal parameters.

Reset
REQ-025 While rst=1, regardless of the clock, the block SHALL force: state=IDLE, ask_for_data=0, sdo=1, busy=0, frame_done=0, frame_cnt=0, and shift register and counters cleared.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no frame_done and no frame_cnt increment.
REQ-027 The first frame after reset release SHALL begin only on a clock edge where enable=1.

Structure
REQ-028 A shared package nibser_pkg SHALL hold the state encoding and the default values of DATA_W, WAIT_CYC and CNT_W.
REQ-029 The block SHALL be a single module; no sub-module is needed (FSM, counters and shifter are inline).

Verification
REQ-030 Reset: assert rst asynchronously between edges -> outputs immediately reach reset values (sdo=1, ask_for_data=0, frame_cnt=0).
REQ-031 Single frame: enable pulsed for 1 cycle with data=4'hA stable from the WAIT cycles -> ask_for_data high 1 cycle, then after 2 cycles sdo = 0,1,0,1,0,1; frame_done pulses once; frame_cnt=1.
REQ-032 Sample window: data=4'h3 during REQ, changed to 4'hC within the first WAIT cycle -> serialized bits 1,1,0,0 (4'hC captured).
REQ-033 Streaming: enable held high; producer increments data on each ask_for_data rising edge starting from 0 -> frames carry 1,2,3,...; a 10-cycle period (9 frame cycles + 1 IDLE); frame_cnt wraps 255->0 after 256 frames.
REQ-034 Mid-frame events: enable dropped during SHIFT -> frame completes, then IDLE. rst pulsed during SHIFT bit 2 -> sdo=1 at once, no frame_done, frame_cnt unchanged at 0.
